resp_framer: RTL and testbench

Host-bound response framer for the password-manager control path. Accepts one response (status code plus up to 16 payload bytes) from the control FSM per handshake. Serializes it into a byte stream on a valid/ready interface that feeds the UART transmitter. Frame format: SOF, STATUS, LEN, payload, CHK.

---
 rtl/keylime_pkg.sv | 24 ++
 rtl/resp_byte_sel.sv | 23 ++
 rtl/resp_framer.sv | 182 ++++++++++++++++++
 tb/tb_resp_framer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keylime_pkg.sv
// Shared constants and types for the keylime control path.
// RESP_FRAMER_CHKSUM_EN adds the checksum state to the framer state enum.
package keylime_pkg;

  localparam logic [7:0] STS_OK        = 8'h00;
  localparam logic [7:0] STS_BAD_PW    = 8'h01;
  localparam logic [7:0] STS_UNK_CMD   = 8'h02;
  localparam logic [7:0] STS_STOR_FAIL = 8'h03;

  localparam logic [7:0] SOF_DEFAULT   = 8'hA5;

  typedef enum logic [2:0] {
    RF_IDLE = 3'd0,
    RF_SOF  = 3'd1,
    RF_STAT = 3'd2,
    RF_LEN  = 3'd3,
    RF_PAY  = 3'd4
`ifdef RESP_FRAMER_CHKSUM_EN
    ,
    RF_CHK  = 3'd5
`endif
  } resp_framer_state_e;

endpackage

// File: rtl/resp_byte_sel.sv
// Picks one payload byte out of the latched response word; index 0 is the
// most significant byte.
module resp_byte_sel #(
  parameter int DATA_WIDTH = 128,
  parameter int IDX_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [7:0]            byte_o
);

  localparam int NBYTES = DATA_WIDTH / 8;

  always_comb begin
    byte_o = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_i == IDX_W'(i)) begin
        byte_o = data_i[DATA_WIDTH-1-8*i -: 8];
      end
    end
  end

endmodule

// File: rtl/resp_framer.sv
// Serializes one control-FSM response into SOF, STATUS, LEN, payload[, CHK].
// Define RESP_FRAMER_CHKSUM_EN to append the XOR checksum byte.
module resp_framer
  import keylime_pkg::*;
#(
  parameter int         DATA_WIDTH = 128,
  parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_status,
  input  logic [4:0]            req_len,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  output logic                  busy
);

  localparam int         NBYTES     = DATA_WIDTH / 8;
  localparam int         IDX_W      = $clog2(NBYTES);
  localparam logic [4:0] NBYTES_LEN = 5'(NBYTES);

  resp_framer_state_e    state_q, state_d;
  logic [7:0]            status_q, status_d;
  logic [4:0]            len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
`ifdef RESP_FRAMER_CHKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic                  tx_fire;
  logic                  pay_last;
  logic                  payload_done;
  logic [IDX_W-1:0]      sel_idx;
  logic [7:0]            sel_byte;

  assign tx_fire  = tx_valid_q && tx_ready;
  assign pay_last = (5'(cnt_q) + 5'd1) == len_q;

  // The byte to present next: byte 0 when leaving LEN, otherwise the one after cnt_q.
  assign sel_idx  = (state_q == RF_PAY) ? cnt_q + 1'b1 : '0;

  resp_byte_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_byte_sel (
    .data_i (data_q),
    .idx_i  (sel_idx),
    .byte_o (sel_byte)
  );

  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    len_d        = len_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_byte_d    = tx_byte_q;
    payload_done = 1'b0;
`ifdef RESP_FRAMER_CHKSUM_EN
    chk_d        = chk_q;
    if (tx_fire && (state_q inside {RF_STAT, RF_LEN, RF_PAY})) begin
      chk_d = chk_q ^ tx_byte_q;
    end
`endif

    case (state_q)
      RF_IDLE: begin
        if (req_valid) begin
          status_d   = req_status;
          len_d      = (req_len > NBYTES_LEN) ? NBYTES_LEN : req_len;
          data_d     = req_data;
          cnt_d      = '0;
`ifdef RESP_FRAMER_CHKSUM_EN
          chk_d      = 8'h00;
`endif
          state_d    = RF_SOF;
          tx_valid_d = 1'b1;
          tx_byte_d  = SOF_BYTE;
        end
      end
      RF_SOF: begin
        if (tx_fire) begin
          state_d   = RF_STAT;
          tx_byte_d = status_q;
        end
      end
      RF_STAT: begin
        if (tx_fire) begin
          state_d   = RF_LEN;
          tx_byte_d = {3'b000, len_q};
        end
      end
      RF_LEN: begin
        if (tx_fire) begin
          if (len_q != 5'd0) begin
            state_d   = RF_PAY;
            cnt_d     = '0;
            tx_byte_d = sel_byte;
          end else begin
            payload_done = 1'b1;
          end
        end
      end
      RF_PAY: begin
        if (tx_fire) begin
          if (pay_last) begin
            payload_done = 1'b1;
          end else begin
            cnt_d     = cnt_q + 1'b1;
            tx_byte_d = sel_byte;
          end
        end
      end
`ifdef RESP_FRAMER_CHKSUM_EN
      RF_CHK: begin
        if (tx_fire) begin
          state_d    = RF_IDLE;
          tx_valid_d = 1'b0;
          tx_byte_d  = 8'h00;
        end
      end
`endif
      default: begin
        state_d    = RF_IDLE;
        tx_valid_d = 1'b0;
        tx_byte_d  = 8'h00;
      end
    endcase

    // chk_d already includes the byte just accepted, so it is the final sum.
    if (payload_done) begin
`ifdef RESP_FRAMER_CHKSUM_EN
      state_d    = RF_CHK;
      tx_byte_d  = chk_d;
`else
      state_d    = RF_IDLE;
      tx_valid_d = 1'b0;
      tx_byte_d  = 8'h00;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RF_IDLE;
      status_q   <= 8'h00;
      len_q      <= 5'd0;
      data_q     <= '0;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
`ifdef RESP_FRAMER_CHKSUM_EN
      chk_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
`ifdef RESP_FRAMER_CHKSUM_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign req_ready = (state_q == RF_IDLE);
  assign busy      = (state_q != RF_IDLE);
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_byte_q;

endmodule

// File: tb/tb_resp_framer.sv
// Self-checking bench for resp_framer: a frame-level byte model plus directed
// and randomized traffic. Follows RESP_FRAMER_CHKSUM_EN like the design.
module tb_resp_framer;
  import keylime_pkg::*;

  typedef logic [7:0] byte_q_t[$];

`ifdef RESP_FRAMER_CHKSUM_EN
  localparam int CHK_N = 1;
`else
  localparam int CHK_N = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_status;
  logic [4:0]   req_len;
  logic [127:0] req_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [7:0]   tx_byte;
  logic         busy;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;
  bit rdy_mode = 1'b0;

  // Model state: bytes still owed by the current frame, plus a log of every
  // handshaken byte and the cycle it was accepted on.
  logic [7:0] exp_q[$];
  logic [7:0] hs_b[$];
  int         hs_c[$];
  int         cyc = 0;
  int         acc_cnt = 0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;

  resp_framer #(
    .DATA_WIDTH (128),
    .SOF_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_status (req_status),
    .req_len    (req_len),
    .req_data   (req_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_byte    (tx_byte),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void build_frame(input logic [7:0] st, input logic [4:0] ln, input logic [127:0] d);
    int n;
    logic [7:0] b;
    logic [7:0] c;
    n = (ln > 5'd16) ? 16 : int'(ln);
    exp_q.push_back(8'hA5);
    exp_q.push_back(st);
    exp_q.push_back(8'(n));
    c = st ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      b = 8'(d >> (8 * (15 - i)));
      exp_q.push_back(b);
      c = c ^ b;
    end
    if (CHK_N == 1) exp_q.push_back(c);
  endfunction

  // Model advance: accept a request when idle, otherwise consume on handshake.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      cyc++;
      if (exp_q.size() == 0) begin
        if (req_valid) begin
          build_frame(req_status, req_len, req_data);
          acc_cnt++;
        end
      end else if (tx_ready) begin
        hs_b.push_back(exp_q[0]);
        hs_c.push_back(cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  // Compare process: every cycle, outputs against the model away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (!rst_n) begin
        checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
        checkOutput("rst_tx_byte", 32'(tx_byte), 32'h00);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        prev_stall = 1'b0;
      end else begin
        checkOutput("tx_valid", 32'(tx_valid), 32'(exp_q.size() != 0));
        checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
        checkOutput("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
        if (exp_q.size() != 0) checkOutput("tx_byte", 32'(tx_byte), 32'(exp_q[0]));
        if (prev_stall) begin
          checkOutput("stall_valid", 32'(tx_valid), 32'd1);
          checkOutput("stall_byte", 32'(tx_byte), 32'(prev_byte));
        end
        prev_stall = tx_valid && !tx_ready;
        prev_byte  = tx_byte;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rdy_mode ? ($urandom_range(0, 99) < 60) : 1'b1;
    end
  end

  // Called at posedge+1: presents one request for a single cycle.
  task automatic applyStimulus(input logic [7:0] st, input logic [4:0] ln, input logic [127:0] d);
    req_valid  = 1'b1;
    req_status = st;
    req_len    = ln;
    req_data   = d;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_log(input string name, input int base, input byte_q_t lit);
    checkOutput({name, "_count"}, 32'(hs_b.size() - base), 32'(lit.size()));
    for (int i = 0; i < lit.size(); i++) begin
      if (base + i < hs_b.size()) checkOutput({name, "_byte"}, 32'(hs_b[base+i]), 32'(lit[i]));
    end
  endtask

  initial begin
    int base;
    int n;
    byte_q_t lit;

    req_valid  = 1'b0;
    req_status = 8'h00;
    req_len    = 5'd0;
    req_data   = '0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    checkOutput("init_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("init_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n = 1'b1;

    $display("[TB] frame len=2");
    base = hs_b.size();
    applyStimulus(STS_OK, 5'd2, {8'h12, 8'h34, 112'h0});
    wait_idle(100);
    lit = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
    if (CHK_N == 1) lit.push_back(8'h24);
    check_log("t1", base, lit);
    for (int i = base + 1; i < hs_b.size(); i++) checkOutput("t1_spacing", 32'(hs_c[i] - hs_c[i-1]), 32'd1);

    $display("[TB] frame len=0");
    base = hs_b.size();
    applyStimulus(STS_BAD_PW, 5'd0, {4{32'hDEADBEEF}});
    wait_idle(100);
    lit = '{8'hA5, 8'h01, 8'h00};
    if (CHK_N == 1) lit.push_back(8'h01);
    check_log("t2", base, lit);

    $display("[TB] saturated length");
    base = hs_b.size();
    applyStimulus(STS_OK, 5'd20, {128{1'b1}});
    wait_idle(200);
    lit = '{8'hA5, 8'h00, 8'h10};
    for (int i = 0; i < 16; i++) lit.push_back(8'hFF);
    if (CHK_N == 1) lit.push_back(8'h10);
    check_log("t3", base, lit);

    $display("[TB] stalled len=4");
    rdy_mode = 1'b1;
    base = hs_b.size();
    applyStimulus(STS_UNK_CMD, 5'd4, {8'h11, 8'h22, 8'h33, 8'h44, 96'h0});
    wait_idle(400);
    rdy_mode = 1'b0;
    lit = '{8'hA5, 8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    if (CHK_N == 1) lit.push_back(8'h42);
    check_log("t4", base, lit);

    $display("[TB] reset during payload");
    @(posedge clk);
    #1;
    base = hs_b.size();
    applyStimulus(STS_OK, 5'd8, {64'h0102030405060708, 64'h0});
    n = 0;
    while (hs_b.size() - base < 6 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("t5_reach_pay3", 32'(hs_b.size() - base), 32'd6);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = hs_b.size();
    applyStimulus(STS_OK, 5'd3, {8'hAA, 8'hBB, 8'hCC, 104'h0});
    wait_idle(100);
    lit = '{8'hA5, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    if (CHK_N == 1) lit.push_back(8'hDE);
    check_log("t5", base, lit);

    $display("[TB] back-to-back");
    base = hs_b.size();
    n = acc_cnt;
    req_valid  = 1'b1;
    req_status = STS_STOR_FAIL;
    req_len    = 5'd0;
    for (int i = 0; i < 50 && acc_cnt < n + 2; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    checkOutput("t6_accepts", 32'(acc_cnt - n), 32'd2);
    wait_idle(100);
    lit = '{8'hA5, 8'h03, 8'h00};
    if (CHK_N == 1) lit.push_back(8'h03);
    lit = {lit, lit};
    check_log("t6", base, lit);
    if (hs_b.size() - base == 2 * (3 + CHK_N))
      checkOutput("t6_gap", 32'(hs_c[base+3+CHK_N] - hs_c[base+2+CHK_N]), 32'd2);

    $display("[TB] random traffic");
    rdy_mode = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      req_valid  = ($urandom_range(0, 3) == 0);
      req_status = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      req_len    = 5'($urandom_range(0, 20));
      req_data   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_idle(500);
    rdy_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

endmodule
